// File: rtl/sap_control_sequencer_pkg.sv
// Shared definitions for the SAP control sequencer: opcodes, sequencer state
// codes and control-word bit positions (also used by the computer top and benches).
package sap_pkg;

    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_LDA = 4'h1;
    localparam logic [3:0] OP_ADD = 4'h2;
    localparam logic [3:0] OP_SUB = 4'h3;
    localparam logic [3:0] OP_STA = 4'h4;
    localparam logic [3:0] OP_LDI = 4'h5;
    localparam logic [3:0] OP_JMP = 4'h6;
    localparam logic [3:0] OP_JZ  = 4'h8;
    localparam logic [3:0] OP_OUT = 4'hE;
    localparam logic [3:0] OP_HLT = 4'hF;

    // T2..T4 must stay contiguous: execute steps are addressed as offsets from T2.
    localparam int ST_W = 4;
    localparam logic [ST_W-1:0] ST_IDLE  = 4'd0;
    localparam logic [ST_W-1:0] ST_CLR   = 4'd1;
    localparam logic [ST_W-1:0] ST_T0    = 4'd2;
    localparam logic [ST_W-1:0] ST_T1    = 4'd3;
    localparam logic [ST_W-1:0] ST_T2    = 4'd4;
    localparam logic [ST_W-1:0] ST_T3    = 4'd5;
    localparam logic [ST_W-1:0] ST_T4    = 4'd6;
    localparam logic [ST_W-1:0] ST_PAUSE = 4'd7;
    localparam logic [ST_W-1:0] ST_HALT  = 4'd8;

    localparam int CW_W         = 17;
    localparam int CW_PC_INC    = 0;
    localparam int CW_PC_OUT    = 1;
    localparam int CW_PC_LOAD   = 2;
    localparam int CW_PC_CLR    = 3;
    localparam int CW_MAR_IN    = 4;
    localparam int CW_RAM_OUT   = 5;
    localparam int CW_RAM_IN    = 6;
    localparam int CW_IR_IN     = 7;
    localparam int CW_IR_OUT    = 8;
    localparam int CW_REG1_IN   = 9;
    localparam int CW_REG1_OUT  = 10;
    localparam int CW_REG1_CLR  = 11;
    localparam int CW_REGB_IN   = 12;
    localparam int CW_ALU_OUT   = 13;
    localparam int CW_ALU_SUB   = 14;
    localparam int CW_FLAGS_IN  = 15;
    localparam int CW_OUT_IN    = 16;

    typedef logic [CW_W-1:0] cw_t;

    function automatic logic [2:0] tstate_of(input logic [ST_W-1:0] st);
        logic [2:0] ts;
        case (st)
            ST_T0:   ts = 3'd0;
            ST_T1:   ts = 3'd1;
            ST_T2:   ts = 3'd2;
            ST_T3:   ts = 3'd3;
            ST_T4:   ts = 3'd4;
            default: ts = 3'd7;
        endcase
        return ts;
    endfunction

endpackage

// File: rtl/sap_control_sequencer_if.sv
// Control-bus bundle between the sequencer (master) and the datapath (slave):
// run/opcode/flag inputs plus every load/drive strobe and debug status.
interface sap_control_sequencer_if #(
    parameter int OPCODE_W = 4,
    parameter int TSTATE_W = 3
);
    logic                run;
    logic [OPCODE_W-1:0] opcode;
    logic                zero_flag;
    logic                pc_inc, pc_out, pc_load, pc_clr;
    logic                mar_in;
    logic                ram_out, ram_in;
    logic                ir_in, ir_out;
    logic                reg1_data_in, reg1_data_out, reg1_clr;
    logic                regb_in;
    logic                alu_out, alu_sub, flags_in;
    logic                out_in;
    logic                halted;
    logic [TSTATE_W-1:0] tstate;

    modport master (
        input  run, opcode, zero_flag,
        output pc_inc, pc_out, pc_load, pc_clr, mar_in, ram_out, ram_in,
               ir_in, ir_out, reg1_data_in, reg1_data_out, reg1_clr, regb_in,
               alu_out, alu_sub, flags_in, out_in, halted, tstate
    );

    modport slave (
        output run, opcode, zero_flag,
        input  pc_inc, pc_out, pc_load, pc_clr, mar_in, ram_out, ram_in,
               ir_in, ir_out, reg1_data_in, reg1_data_out, reg1_clr, regb_in,
               alu_out, alu_sub, flags_in, out_in, halted, tstate
    );
endinterface

// File: rtl/sap_control_sequencer_rom.sv
// Combinational microcode table: (state, opcode, zero_flag) -> control word,
// plus flags marking an instruction's final microstep and a HLT decode.
module sap_microcode_rom
    import sap_pkg::*;
#(
    parameter int OPCODE_W = 4
) (
    input  logic [ST_W-1:0]     state_i,
    input  logic [OPCODE_W-1:0] opcode_i,
    input  logic                zero_flag_i,
    output cw_t                 cw_o,
    output logic                last_o,
    output logic                halt_o
);

    always_comb begin
        cw_o   = '0;
        last_o = 1'b0;
        halt_o = 1'b0;
        case (state_i)
            ST_CLR: begin
                cw_o[CW_PC_CLR]   = 1'b1;
                cw_o[CW_REG1_CLR] = 1'b1;
            end
            ST_T0: begin
                cw_o[CW_PC_OUT] = 1'b1;
                cw_o[CW_MAR_IN] = 1'b1;
            end
            ST_T1: begin
                cw_o[CW_RAM_OUT] = 1'b1;
                cw_o[CW_IR_IN]   = 1'b1;
                cw_o[CW_PC_INC]  = 1'b1;
            end
            ST_T2: begin
                last_o = 1'b1;
                case (opcode_i)
                    OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
                        cw_o[CW_IR_OUT] = 1'b1;
                        cw_o[CW_MAR_IN] = 1'b1;
                        last_o          = 1'b0;
                    end
                    OP_LDI: begin
                        cw_o[CW_IR_OUT]  = 1'b1;
                        cw_o[CW_REG1_IN] = 1'b1;
                    end
                    OP_JMP: begin
                        cw_o[CW_IR_OUT]  = 1'b1;
                        cw_o[CW_PC_LOAD] = 1'b1;
                    end
                    OP_JZ: begin
                        cw_o[CW_IR_OUT]  = zero_flag_i;
                        cw_o[CW_PC_LOAD] = zero_flag_i;
                    end
                    OP_OUT: begin
                        cw_o[CW_REG1_OUT] = 1'b1;
                        cw_o[CW_OUT_IN]   = 1'b1;
                    end
                    OP_HLT:  halt_o = 1'b1;
                    default: ;
                endcase
            end
            ST_T3: begin
                last_o = 1'b1;
                case (opcode_i)
                    OP_LDA: begin
                        cw_o[CW_RAM_OUT] = 1'b1;
                        cw_o[CW_REG1_IN] = 1'b1;
                    end
                    OP_ADD, OP_SUB: begin
                        cw_o[CW_RAM_OUT] = 1'b1;
                        cw_o[CW_REGB_IN] = 1'b1;
                        last_o           = 1'b0;
                    end
                    OP_STA: begin
                        cw_o[CW_REG1_OUT] = 1'b1;
                        cw_o[CW_RAM_IN]   = 1'b1;
                    end
                    default: ;
                endcase
            end
            ST_T4: begin
                last_o = 1'b1;
                if (opcode_i == OP_ADD || opcode_i == OP_SUB) begin
                    cw_o[CW_ALU_OUT]  = 1'b1;
                    cw_o[CW_REG1_IN]  = 1'b1;
                    cw_o[CW_FLAGS_IN] = 1'b1;
                    cw_o[CW_ALU_SUB]  = (opcode_i == OP_SUB);
                end
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/sap_control_sequencer.sv
// SAP fetch/execute sequencer: state register, run sampling at instruction
// boundaries and HALT. Optional macro SEQ_SINGLE_STEP_EN adds step_mode/step.
module sap_control_sequencer
    import sap_pkg::*;
#(
    parameter int OPCODE_W = 4,
    parameter int TSTATE_W = 3
) (
    input logic clk,
    input logic reset,
`ifdef SEQ_SINGLE_STEP_EN
    input logic step_mode,
    input logic step,
`endif
    sap_control_sequencer_if.master bus
);

    logic [ST_W-1:0] state_q, state_d;
    cw_t             cw;
    cw_t             cw_gated;
    logic            last_step;
    logic            is_hlt;
    logic            advance;

    sap_microcode_rom #(.OPCODE_W(OPCODE_W)) u_rom (
        .state_i     (state_q),
        .opcode_i    (bus.opcode),
        .zero_flag_i (bus.zero_flag),
        .cw_o        (cw),
        .last_o      (last_step),
        .halt_o      (is_hlt)
    );

`ifdef SEQ_SINGLE_STEP_EN
    assign advance = !step_mode || step;
`else
    assign advance = 1'b1;
`endif

    // run only matters where an instruction may start: IDLE, PAUSE and final microsteps.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (bus.run) state_d = ST_CLR;
            ST_CLR:   state_d = ST_T0;
            ST_T0:    state_d = ST_T1;
            ST_T1:    state_d = ST_T2;
            ST_T2, ST_T3, ST_T4: begin
                if (is_hlt)         state_d = ST_HALT;
                else if (last_step) state_d = bus.run ? ST_T0 : ST_PAUSE;
                else if (state_q == ST_T2) state_d = ST_T3;
                else                state_d = ST_T4;
            end
            ST_PAUSE: if (bus.run) state_d = ST_T0;
            ST_HALT:  state_d = ST_HALT;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset)       state_q <= ST_IDLE;
        else if (advance) state_q <= state_d;
    end

    assign cw_gated = advance ? cw : '0;

    assign bus.pc_inc        = cw_gated[CW_PC_INC];
    assign bus.pc_out        = cw_gated[CW_PC_OUT];
    assign bus.pc_load       = cw_gated[CW_PC_LOAD];
    assign bus.pc_clr        = cw_gated[CW_PC_CLR];
    assign bus.mar_in        = cw_gated[CW_MAR_IN];
    assign bus.ram_out       = cw_gated[CW_RAM_OUT];
    assign bus.ram_in        = cw_gated[CW_RAM_IN];
    assign bus.ir_in         = cw_gated[CW_IR_IN];
    assign bus.ir_out        = cw_gated[CW_IR_OUT];
    assign bus.reg1_data_in  = cw_gated[CW_REG1_IN];
    assign bus.reg1_data_out = cw_gated[CW_REG1_OUT];
    assign bus.reg1_clr      = cw_gated[CW_REG1_CLR];
    assign bus.regb_in       = cw_gated[CW_REGB_IN];
    assign bus.alu_out       = cw_gated[CW_ALU_OUT];
    assign bus.alu_sub       = cw_gated[CW_ALU_SUB];
    assign bus.flags_in      = cw_gated[CW_FLAGS_IN];
    assign bus.out_in        = cw_gated[CW_OUT_IN];

    assign bus.halted = (state_q == ST_HALT);
    assign bus.tstate = TSTATE_W'(tstate_of(state_q));

endmodule

// File: tb/tb_sap_control_sequencer.sv
// Bench for sap_control_sequencer: a small SAP datapath model on the bus, and a
// scoreboard of expected control words / tstate / halted per cycle.
`timescale 1ns/1ps
module tb_sap_control_sequencer;
    import sap_pkg::*;

    typedef struct packed {
        logic [2:0]      ts;
        logic            h;
        logic [CW_W-1:0] cw;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    logic run_b;
    logic step_mode_b = 1'b0;
    logic step_b = 1'b0;
    always #5 clk = ~clk;

    sap_control_sequencer_if #(.OPCODE_W(4), .TSTATE_W(3)) bus ();

    sap_control_sequencer #(.OPCODE_W(4), .TSTATE_W(3)) dut (
        .clk   (clk),
        .reset (reset),
`ifdef SEQ_SINGLE_STEP_EN
        .step_mode (step_mode_b),
        .step      (step_b),
`endif
        .bus   (bus)
    );

    logic [7:0] ram_m [16];
    logic [7:0] prog_img [16];
    logic       ld_req = 1'b0;
    logic [3:0] pc_m, mar_m;
    logic [7:0] ir_m, a_m, b_m, out_m;
    logic       zf_m;
    logic       ovr_en = 1'b0;
    logic [3:0] ovr_op = 4'h0;
    logic       ovr_zf = 1'b0;
    logic [7:0] alu_v, bus_v;
    logic [CW_W-1:0] obs_cw;

    assign bus.run       = run_b;
    assign bus.opcode    = ovr_en ? ovr_op : ir_m[7:4];
    assign bus.zero_flag = ovr_en ? ovr_zf : zf_m;

    always_comb begin
        alu_v = bus.alu_sub ? (a_m - b_m) : (a_m + b_m);
        bus_v = 8'h00;
        if (bus.pc_out)             bus_v = {4'h0, pc_m};
        else if (bus.ram_out)       bus_v = ram_m[mar_m];
        else if (bus.ir_out)        bus_v = {4'h0, ir_m[3:0]};
        else if (bus.reg1_data_out) bus_v = a_m;
        else if (bus.alu_out)       bus_v = alu_v;
    end

    always_comb begin
        obs_cw = '0;
        obs_cw[CW_PC_INC]   = bus.pc_inc;
        obs_cw[CW_PC_OUT]   = bus.pc_out;
        obs_cw[CW_PC_LOAD]  = bus.pc_load;
        obs_cw[CW_PC_CLR]   = bus.pc_clr;
        obs_cw[CW_MAR_IN]   = bus.mar_in;
        obs_cw[CW_RAM_OUT]  = bus.ram_out;
        obs_cw[CW_RAM_IN]   = bus.ram_in;
        obs_cw[CW_IR_IN]    = bus.ir_in;
        obs_cw[CW_IR_OUT]   = bus.ir_out;
        obs_cw[CW_REG1_IN]  = bus.reg1_data_in;
        obs_cw[CW_REG1_OUT] = bus.reg1_data_out;
        obs_cw[CW_REG1_CLR] = bus.reg1_clr;
        obs_cw[CW_REGB_IN]  = bus.regb_in;
        obs_cw[CW_ALU_OUT]  = bus.alu_out;
        obs_cw[CW_ALU_SUB]  = bus.alu_sub;
        obs_cw[CW_FLAGS_IN] = bus.flags_in;
        obs_cw[CW_OUT_IN]   = bus.out_in;
    end

    always @(posedge clk) begin
        if (ld_req) begin
            for (int i = 0; i < 16; i++) ram_m[i] <= prog_img[i];
            pc_m <= 4'h0; mar_m <= 4'h0; ir_m <= 8'h00;
            a_m <= 8'h00; b_m <= 8'h00; out_m <= 8'h00; zf_m <= 1'b0;
        end else begin
            if (bus.pc_clr)       pc_m <= 4'h0;
            else if (bus.pc_load) pc_m <= bus_v[3:0];
            else if (bus.pc_inc)  pc_m <= pc_m + 4'h1;
            if (bus.mar_in) mar_m <= bus_v[3:0];
            if (bus.ram_in) ram_m[mar_m] <= bus_v;
            if (bus.ir_in)  ir_m <= bus_v;
            if (bus.reg1_clr)          a_m <= 8'h00;
            else if (bus.reg1_data_in) a_m <= bus_v;
            if (bus.regb_in)  b_m <= bus_v;
            if (bus.flags_in) zf_m <= (alu_v == 8'h00);
            if (bus.out_in)   out_m <= bus_v;
        end
    end

    int checks = 0;
    int errors = 0;
    int pcinc_cnt = 0;
    logic [3:0] mst;
    logic       jz_pl;
    logic [3:0] jz_nxt;
    exp_t sb[$];

    function automatic logic [CW_W-1:0] b1(input int i);
        return CW_W'(1) << i;
    endfunction

    // Reference microprogram, organised by opcode and execute-step index (T2 = 0).
    function automatic logic [CW_W-1:0] m_cw(input logic [3:0] st, input logic [3:0] op, input logic zf);
        logic [CW_W-1:0] c;
        int k;
        c = '0;
        k = int'(st) - int'(ST_T2);
        if (st == ST_CLR)     c = b1(CW_PC_CLR) | b1(CW_REG1_CLR);
        else if (st == ST_T0) c = b1(CW_PC_OUT) | b1(CW_MAR_IN);
        else if (st == ST_T1) c = b1(CW_RAM_OUT) | b1(CW_IR_IN) | b1(CW_PC_INC);
        else if (k >= 0 && k <= 2) begin
            case (op)
                OP_LDA: c = (k == 0) ? (b1(CW_IR_OUT) | b1(CW_MAR_IN)) :
                            (k == 1) ? (b1(CW_RAM_OUT) | b1(CW_REG1_IN)) : '0;
                OP_ADD, OP_SUB:
                        c = (k == 0) ? (b1(CW_IR_OUT) | b1(CW_MAR_IN)) :
                            (k == 1) ? (b1(CW_RAM_OUT) | b1(CW_REGB_IN)) :
                            (b1(CW_ALU_OUT) | b1(CW_REG1_IN) | b1(CW_FLAGS_IN) |
                             ((op == OP_SUB) ? b1(CW_ALU_SUB) : '0));
                OP_STA: c = (k == 0) ? (b1(CW_IR_OUT) | b1(CW_MAR_IN)) :
                            (k == 1) ? (b1(CW_REG1_OUT) | b1(CW_RAM_IN)) : '0;
                OP_LDI: c = (k == 0) ? (b1(CW_IR_OUT) | b1(CW_REG1_IN)) : '0;
                OP_JMP: c = (k == 0) ? (b1(CW_IR_OUT) | b1(CW_PC_LOAD)) : '0;
                OP_JZ:  c = (k == 0 && zf) ? (b1(CW_IR_OUT) | b1(CW_PC_LOAD)) : '0;
                OP_OUT: c = (k == 0) ? (b1(CW_REG1_OUT) | b1(CW_OUT_IN)) : '0;
                default: c = '0;
            endcase
        end
        return c;
    endfunction

    function automatic int m_len(input logic [3:0] op);
        case (op)
            OP_LDA, OP_STA: return 2;
            OP_ADD, OP_SUB: return 3;
            default:        return 1;
        endcase
    endfunction

    function automatic logic [3:0] m_next(input logic [3:0] st, input logic run, input logic [3:0] op);
        case (st)
            ST_IDLE:  return run ? ST_CLR : ST_IDLE;
            ST_CLR:   return ST_T0;
            ST_T0:    return ST_T1;
            ST_T1:    return ST_T2;
            ST_PAUSE: return run ? ST_T0 : ST_PAUSE;
            ST_HALT:  return ST_HALT;
            default: begin
                if (int'(st) - int'(ST_T2) + 1 >= m_len(op))
                    return (op == OP_HLT) ? ST_HALT : (run ? ST_T0 : ST_PAUSE);
                return st + 4'd1;
            end
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        exp_t e, g;
        logic [3:0] op, st0;
        logic gate;
        int nd;
        op   = bus.opcode;
        st0  = mst;
        gate = !step_mode_b || step_b;
        e.ts = (mst >= ST_T0 && mst <= ST_T4) ? 3'(mst - ST_T0) : 3'd7;
        e.h  = (mst == ST_HALT);
        e.cw = gate ? m_cw(mst, op, bus.zero_flag) : '0;
        sb.push_back(e);
        @(negedge clk);
        g = sb.pop_front();
        chk("tstate", 32'(bus.tstate), 32'(g.ts));
        chk("halted", 32'(bus.halted), 32'(g.h));
        chk("ctrl_word", 32'(obs_cw), 32'(g.cw));
        nd = int'(bus.pc_out) + int'(bus.ram_out) + int'(bus.ir_out) +
             int'(bus.reg1_data_out) + int'(bus.alu_out);
        chk("one_bus_driver", 32'(nd <= 1), 32'd1);
        if (bus.pc_inc) pcinc_cnt++;
        if (st0 == ST_T2 && op == OP_JZ) jz_pl = bus.pc_load;
        @(posedge clk);
        if (!reset)    mst = ST_IDLE;
        else if (gate) mst = m_next(mst, run_b, op);
        if (st0 == ST_T2 && op == OP_JZ) jz_nxt = mst;
        #1;
    endtask

    task automatic reset_load();
        reset  = 1'b0;
        run_b  = 1'b0;
        ld_req = 1'b1;
        tick();
        ld_req = 1'b0;
        tick();
        reset = 1'b1;
    endtask

    task automatic clear_img();
        for (int i = 0; i < 16; i++) prog_img[i] = 8'h00;
    endtask

    task automatic run_to(input string tag, input logic [3:0] target, input int bound);
        for (int i = 0; i < bound && mst != target; i++) tick();
        chk(tag, 32'(mst), 32'(target));
    endtask

    initial begin
        int n;
        reset = 1'b0;
        run_b = 1'b0;
        mst   = ST_IDLE;
        jz_pl = 1'b0;
        jz_nxt = ST_IDLE;
        @(posedge clk);
        #1;

        // Reset state and LDA/ADD/OUT/HLT program
        clear_img();
        prog_img[0] = 8'h1E; prog_img[1] = 8'h2F; prog_img[2] = 8'hE0; prog_img[3] = 8'hF0;
        prog_img[14] = 8'h05; prog_img[15] = 8'h03;
        reset_load();
        chk("reset_tstate", 32'(bus.tstate), 32'd7);
        chk("reset_ctrl", 32'(obs_cw), 32'd0);
        run_b = 1'b1;
        tick();
        chk("clr_state", 32'(mst), 32'(ST_CLR));
        tick();
        n = 0;
        while (mst != ST_HALT && n < 40) begin
            tick();
            n++;
        end
        chk("prog1_cycles", 32'(n), 32'd15);
        tick();
        chk("prog1_out", 32'(out_m), 32'h08);
        chk("prog1_halted", 32'(bus.halted), 32'd1);
        run_b = 1'b0;
        tick();
        run_b = 1'b1;
        tick();
        chk("halt_ignores_run", 32'(bus.halted), 32'd1);

        // Reset in the middle of ADD at T3
        reset_load();
        run_b = 1'b1;
        n = 0;
        while (!(mst == ST_T3 && bus.opcode == OP_ADD) && n < 30) begin
            tick();
            n++;
        end
        chk("reach_add_t3", 32'(bus.tstate), 32'd3);
        reset = 1'b0;
        tick();
        reset = 1'b1;
        run_b = 1'b0;
        chk("midreset_tstate", 32'(bus.tstate), 32'd7);
        chk("midreset_ctrl", 32'(obs_cw), 32'd0);
        chk("midreset_halted", 32'(bus.halted), 32'd0);
        tick();
        run_b = 1'b1;
        tick();
        chk("clr_pc_clr", 32'(bus.pc_clr), 32'd1);
        chk("clr_reg1_clr", 32'(bus.reg1_clr), 32'd1);
        tick();

        // SUB to zero then JZ taken; then nonzero so JZ falls through
        for (int pass = 0; pass < 2; pass++) begin
            clear_img();
            prog_img[0] = 8'h53; prog_img[1] = 8'h3F; prog_img[2] = 8'h8A;
            prog_img[3] = 8'hF0; prog_img[10] = 8'hF0;
            prog_img[15] = (pass == 0) ? 8'h03 : 8'h01;
            jz_pl  = 1'bx;
            jz_nxt = ST_IDLE;
            reset_load();
            run_b = 1'b1;
            run_to("jz_halt", ST_HALT, 60);
            chk("jz_pc_load", 32'(jz_pl), (pass == 0) ? 32'd1 : 32'd0);
            chk("jz_next_t0", 32'(jz_nxt), 32'(ST_T0));
            chk("jz_final_pc", 32'(pc_m), (pass == 0) ? 32'hB : 32'h4);
        end

        // run dropped during T1 of LDA: completes, then PAUSE, then resume
        clear_img();
        prog_img[0] = 8'h1E; prog_img[1] = 8'hF0; prog_img[14] = 8'h05;
        reset_load();
        run_b = 1'b1;
        run_to("reach_t1", ST_T1, 10);
        run_b = 1'b0;
        n = 0;
        while (mst != ST_PAUSE && n < 10) begin
            tick();
            n++;
        end
        chk("pause_after_lda", 32'(n), 32'd3);
        chk("lda_loaded", 32'(a_m), 32'h05);
        tick();
        tick();
        run_b = 1'b1;
        tick();
        chk("resume_tstate", 32'(bus.tstate), 32'd0);
        chk("resume_no_clr", 32'(bus.pc_clr), 32'd0);
        chk("resume_pc", 32'(pc_m), 32'h1);

        // Every opcode with both flag values: microstep count and driver exclusivity
        for (int op = 0; op < 16; op++) begin
            for (int zf = 0; zf < 2; zf++) begin
                reset_load();
                ovr_en = 1'b1;
                ovr_op = 4'(op);
                ovr_zf = 1'(zf);
                run_b  = 1'b1;
                run_to("sweep_t0", ST_T0, 5);
                tick();
                tick();
                n = 0;
                while (mst != ST_T0 && mst != ST_HALT && n < 8) begin
                    tick();
                    n++;
                end
                chk("sweep_len", 32'(n), 32'(m_len(4'(op))));
                if (op == 7 || (op >= 9 && op <= 13))
                    chk("undef_len", 32'(n), 32'd1);
                ovr_en = 1'b0;
            end
        end

`ifdef SEQ_SINGLE_STEP_EN
        // Single-step: one pc_inc per instruction, nothing between pulses
        clear_img();
        prog_img[0] = 8'h55; prog_img[1] = 8'hE0; prog_img[2] = 8'hF0;
        reset_load();
        run_b = 1'b1;
        step_mode_b = 1'b1;
        pcinc_cnt = 0;
        for (int i = 0; i < 200 && mst != ST_HALT; i++) begin
            step_b = (i % 4 == 0);
            tick();
        end
        step_b = 1'b0;
        chk("step_halted", 32'(bus.halted), 32'd1);
        chk("step_pc_inc", 32'(pcinc_cnt), 32'd3);
        chk("step_out", 32'(out_m), 32'h05);
        step_mode_b = 1'b0;
`endif

        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
